// File: rtl/addr8s_result_checker.sv
// Registered result checker for the addr8s signed adders: recomputes the exact
// 9-bit sum, flags mismatches, counts traffic/errors and raises a sticky alarm.
module addr8s_result_checker #(
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [8:0]       sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_sum,
    output logic             out_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count,
    output logic [24:0]      first_err,
    output logic             first_err_vld,
    output logic             alarm,
    input  logic             clr
);

    typedef enum logic {
        MONITOR = 1'b0,
        ALARM   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

    state_t           state, state_nxt;
    logic [8:0]       golden;
    logic             mismatch;
    logic             accept;
    logic [CNT_W-1:0] txn_nxt, err_nxt;

    // Sign extension to 9 bits makes the sum exact for every operand pair.
    assign golden   = {a[7], a} + {b[7], b};
    assign mismatch = (sum != golden);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign alarm    = (state == ALARM);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        txn_nxt = txn_count;
        err_nxt = err_count;
        if (clr) begin
            txn_nxt = '0;
            err_nxt = '0;
        end else if (accept) begin
            if (txn_count != CNT_MAX) txn_nxt = txn_count + CNT_W'(1);
            if (mismatch && err_count != CNT_MAX) err_nxt = err_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = MONITOR;
        else if (state == MONITOR && err_nxt >= THRESH)
            state_nxt = ALARM;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_err   <= mismatch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            err_count <= '0;
            state     <= MONITOR;
        end else begin
            txn_count <= txn_nxt;
            err_count <= err_nxt;
            state     <= state_nxt;
        end
    end

    // Capture holds the first offending transaction until reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err     <= '0;
            first_err_vld <= 1'b0;
        end else if (clr) begin
            first_err     <= '0;
            first_err_vld <= 1'b0;
        end else if (accept && mismatch && !first_err_vld) begin
            first_err     <= {a, b, sum};
            first_err_vld <= 1'b1;
        end
    end

endmodule

// File: doc/addr8s_result_checker.md
Name: addr8s_result_checker

Overview:
- Registered checker stage directly downstream of the combinational 8-bit signed adders in the addr8s family.
- Captures each adder result with its operands, recomputes the golden 9-bit signed sum, and flags mismatches.
- Keeps saturating transaction and error counters, a first-error capture, and a sticky alarm FSM.
- Passes results on through a valid/ready handshake; supports fault-injection campaigns on the evolved adders.

Parameters:
- CNT_W, 16, width of transaction and error counters (saturating).
- ALARM_THRESH, 4, error count at which the FSM enters ALARM (1..2^CNT_W-1).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and adder result are valid.
- in_ready  output  1  stage can accept this cycle.
- a  input  8  operand A[7:0], two's complement.
- b  input  8  operand B[7:0], two's complement.
- sum  input  9  adder output O[8:0], O[8] = MSB.
- out_valid  output  1  registered result available.
- out_ready  input  1  downstream accepts.
- out_sum  output  9  registered adder result, passed unmodified.
- out_err  output  1  registered out_sum != golden sum.
- txn_count  output  CNT_W  accepted transactions, saturating.
- err_count  output  CNT_W  mismatching transactions, saturating.
- first_err  output  25  {a,b,sum} of the first mismatch since reset/clear.
- first_err_vld  output  1  first_err holds data.
- alarm  output  1  FSM is in ALARM.
- clr  input  1  synchronous clear of counters, capture and FSM.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_sum=0, out_err=0, txn_count=0, err_count=0, first_err=0, first_err_vld=0, alarm=0, FSM=MONITOR. in_ready=1 whenever out_valid=0.
- Handshake: in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready. out_valid/out_sum/out_err stay stable while out_valid && !out_ready.
- Latency: 1 cycle; an input accepted in cycle N appears at out_* in N+1. Full throughput with out_ready=1.
- Pop with no push: out_valid falls to 0.
- Golden sum: sign-extend a and b to 9 bits and add; the result is exact with no overflow. out_err = (sum != golden), registered with out_sum.
- Counters, on accept: txn_count+1; err_count+1 on mismatch. Both saturate at all-ones and never wrap.
- first_err: loads {a,b,sum} on the first mismatch accept while first_err_vld=0, then sets first_err_vld=1. Later mismatches leave it unchanged.
- FSM MONITOR -> ALARM when the err_count next-value >= ALARM_THRESH. alarm=1 from the following cycle. ALARM is sticky; the checker keeps passing data and counting.
- clr=1 (sync): counters, first_err, first_err_vld and alarm go to 0; FSM=MONITOR. The out_* pipeline register is not affected.
- clr in the same cycle as an accept: clear wins for counters and capture; data still passes.
- Reset mid-transfer: the held output is discarded and out_valid=0 immediately.

Test Plan:
- Reset, then a=0x7F, b=0x01, sum=0x080, out_ready=1 -> next cycle out_valid=1, out_sum=0x080, out_err=0, txn_count=1.
- a=0x80, b=0x80, sum=0x100 (golden -256) -> out_err=0. Repeat with sum=0x000 -> out_err=1, err_count=1, first_err={0x80,0x80,0x000}, first_err_vld=1.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum held, txn_count increments only once. Release -> throughput of 1 per cycle resumes.
- Four consecutive bad sums, ALARM_THRESH=4 -> alarm=1 the cycle after the 4th accept. A 5th good sum leaves alarm=1 and first_err unchanged. clr -> alarm=0, counts=0.
- CNT_W=4 with 20 erroneous transfers -> err_count and txn_count stick at 15.
- rst_n low asynchronously while out_valid=1, out_ready=0 -> all outputs return to reset values without waiting for a clock edge.
